// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, grant and write-enable types for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } gnt_e;

   // A transaction whose byte enables are all clear is a read
   localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way grant picker; ARB_ROUND_ROBIN_EN selects round-robin on conflicts
module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic ls_req,
   input  gnt_e last_grant,
   output gnt_e grant
);

`ifdef ARB_ROUND_ROBIN_EN
   // On a conflict hand the grant to whichever port did not win last time
   always_comb begin
      grant = GNT_IF;
      if (ls_req && if_req) begin
         grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
      end else if (ls_req) begin
         grant = GNT_LS;
      end
   end
`else
   // Fixed-priority mode has no history, so the last grant is deliberately ignored
   logic w_unused_last;
   assign w_unused_last = last_grant;

   // Load/store always beats fetch when both ask
   always_comb begin
      grant = GNT_IF;
      if (ls_req) begin
         grant = GNT_LS;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store; ARB_ROUND_ROBIN_EN enables round-robin
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [3:0]        ls_we,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Counter only needs to reach MEM_LAT; it stops there instead of wrapping
   localparam int              CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

   state_e            r_state;
   state_e            w_next_state;
   gnt_e              r_gnt;
   gnt_e              w_pick;
   gnt_e              w_last_grant;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [3:0]        r_we;
   logic              w_any_req;
   logic              w_grant_en;
   logic              w_cnt_done;

   assign w_any_req  = if_req | ls_req;
   assign w_cnt_done = (r_cnt == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
   gnt_e r_last_grant;

   // Remember every winner so the next conflict goes to the other port
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= GNT_IF;
      end else if (w_grant_en) begin
         r_last_grant <= w_pick;
      end
   end

   assign w_last_grant = r_last_grant;
`else
   assign w_last_grant = GNT_IF;
`endif

   arb_pick2 u_pick (
      .if_req     (if_req),
      .ls_req     (ls_req),
      .last_grant (w_last_grant),
      .grant      (w_pick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state plus the strobe and ack outputs decoded from the current state
   always_comb begin
      w_next_state = r_state;
      w_grant_en   = 1'b0;
      mem_en       = 1'b0;
      mem_we       = WE_NONE;
      if_ack       = 1'b0;
      ls_ack       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_grant_en   = 1'b1;
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_cnt == '0) begin
               mem_en = 1'b1;
               mem_we = r_we;
            end
            if (w_cnt_done) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if_ack       = (r_gnt == GNT_IF);
            ls_ack       = (r_gnt == GNT_LS);
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Latch the winning request, count out the memory latency and capture read data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt   <= GNT_IF;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= WE_NONE;
         r_rdata <= '0;
      end else if (w_grant_en) begin
         r_gnt <= w_pick;
         r_cnt <= '0;
         if (w_pick == GNT_LS) begin
            r_addr  <= ls_addr;
            r_wdata <= ls_wdata;
            r_we    <= ls_we;
         end else begin
            r_addr <= if_addr;
            r_we   <= WE_NONE;
         end
      end else if (r_state == ST_ACCESS) begin
         if (!w_cnt_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (r_we == WE_NONE) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_rdata  = r_rdata;
   assign ls_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter with a transaction-level reference model
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MEM_LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_we;
   logic        ls_ack;
   logic [31:0] ls_rdata;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_we(ls_we),
      .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int en_count = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h0050_0093;
      return 32'h1357_0000 + 32'(i) * 32'h0101_0011;
   endfunction

   // Memory that answers exactly MEM_LAT cycles after a read strobe and returns junk otherwise
   logic [31:0] phys_mem [64];
   logic        phys_init = 1'b0;
   logic        pv [1:MEM_LAT];
   logic [31:0] pa [1:MEM_LAT];
   logic [31:0] garbage;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      garbage <= $urandom;
      if (mem_en) en_count <= en_count + 1;
      if (!phys_init) begin
         for (int i = 0; i < 64; i++) phys_mem[i] <= init_word(i);
         phys_init <= 1'b1;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) phys_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (reset) begin
         for (int i = 1; i <= MEM_LAT; i++) pv[i] <= 1'b0;
      end else begin
         pv[1] <= mem_en && (mem_we == 4'b0000);
         pa[1] <= mem_addr;
         for (int i = 2; i <= MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
      end
   end

   assign mem_rdata = pv[MEM_LAT] ? phys_mem[pa[MEM_LAT][7:2]] : garbage;

   // Reference model: one predicted transaction at a time, timed by arithmetic from its grant cycle
   logic [31:0] ref_mem [64];
   bit          ref_init = 1'b0;
   int          en_cyc = -1, ack_cyc = -1, free_cyc = 0;
   bit          p_ls, last_ls, e_en, win_ls;
   logic [31:0] p_addr, p_wdata, p_rdata, rd_ref;
   logic [3:0]  p_we;
   byte         ack_log[$];

   always @(negedge clk) begin
      if (!ref_init) begin
         for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
         ref_init = 1'b1;
      end
      if (if_ack) ack_log.push_back(8'd0);
      if (ls_ack) ack_log.push_back(8'd1);
      if (reset) begin
         en_cyc = -1; ack_cyc = -1; free_cyc = cyc + 1; rd_ref = '0; last_ls = 1'b0;
      end else begin
         e_en = (cyc == en_cyc);
         check("mem_en", mem_en, e_en);
         check("mem_we", mem_we, e_en ? p_we : 4'h0);
         if (e_en) begin
            check("mem_addr", mem_addr, p_addr);
            if (p_we != 4'h0) begin
               check("mem_wdata", mem_wdata, p_wdata);
               for (int b = 0; b < 4; b++)
                  if (p_we[b]) ref_mem[p_addr[7:2]][8*b +: 8] = p_wdata[8*b +: 8];
               p_rdata = rd_ref;
            end else begin
               p_rdata = ref_mem[p_addr[7:2]];
            end
         end
         check("if_ack", if_ack, (cyc == ack_cyc) && !p_ls);
         check("ls_ack", ls_ack, (cyc == ack_cyc) && p_ls);
         if (cyc == ack_cyc) begin
            if (p_ls) check("ls_rdata", ls_rdata, p_rdata);
            else      check("if_rdata", if_rdata, p_rdata);
            rd_ref = p_rdata;
         end
         if (cyc >= free_cyc && (if_req || ls_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_ls = ls_req && (!if_req || !last_ls);
`else
            win_ls = ls_req;
`endif
            p_ls     = win_ls;
            p_addr   = win_ls ? ls_addr : if_addr;
            p_we     = win_ls ? ls_we : 4'h0;
            p_wdata  = ls_wdata;
            last_ls  = win_ls;
            en_cyc   = cyc + 1;
            ack_cyc  = cyc + MEM_LAT + 2;
            free_cyc = cyc + MEM_LAT + 3;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic if_txn(input logic [31:0] addr, output int t0, output int t_ack, output logic [31:0] rd);
      if_addr = addr; if_req = 1'b1; t0 = cyc; t_ack = -1; rd = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (if_ack) begin
            t_ack = cyc; rd = if_rdata;
            break;
         end
      end
      check("if_ack_seen", 64'(t_ack >= 0), 64'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic ls_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                         output int t0, output int t_ack, output logic [31:0] rd);
      ls_addr = addr; ls_we = we; ls_wdata = wd; ls_req = 1'b1; t0 = cyc; t_ack = -1; rd = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ls_ack) begin
            t_ack = cyc; rd = ls_rdata;
            break;
         end
      end
      check("ls_ack_seen", 64'(t_ack >= 0), 64'd1);
      @(posedge clk); #1;
      ls_req = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_mem_en"}, mem_en, 0);
      check({pfx, "_mem_we"}, mem_we, 0);
      check({pfx, "_mem_addr"}, mem_addr, 0);
      check({pfx, "_mem_wdata"}, mem_wdata, 0);
      check({pfx, "_if_ack"}, if_ack, 0);
      check({pfx, "_ls_ack"}, ls_ack, 0);
      check({pfx, "_if_rdata"}, if_rdata, 0);
      check({pfx, "_ls_rdata"}, ls_rdata, 0);
   endtask

   int          a0, a1, b0, b1, e0, acks, base;
   logic [31:0] rda, rdb;
   byte         exp_order [6];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_we = '0;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      tick(1);

      // Both ports ask in the same cycle: ls first, fetch one full slot later
      fork
         ls_txn(32'h200, 4'hF, 32'hCAFE_F00D, a0, a1, rda);
         if_txn(32'h40, b0, b1, rdb);
      join
      check("conflict_ls_lat", a1 - a0, MEM_LAT + 2);
      check("conflict_if_lat", b1 - b0, 2 * MEM_LAT + 5);

      // Single fetch of a known word
      e0 = en_count;
      if_txn(32'h10, a0, a1, rda);
      check("fetch_lat", a1 - a0, MEM_LAT + 2);
      check("fetch_data", rda, 32'h0050_0093);
      check("fetch_en_pulses", en_count - e0, 1);

      // Single-lane store leaves the read-data register alone
      e0 = en_count;
      ls_txn(32'h104, 4'b0010, 32'h0000_AB00, a0, a1, rda);
      check("store_lat", a1 - a0, MEM_LAT + 2);
      check("store_rdata_kept", rda, 32'h0050_0093);
      check("store_en_pulses", en_count - e0, 1);
      ls_txn(32'h104, 4'b0000, 32'h0, a0, a1, rda);
      check("store_readback", rda, (init_word(1) & 32'hFFFF_00FF) | 32'h0000_AB00);

      // Randomized traffic from both ports, including back-to-back re-requests
      fork
         begin
            int t0, t1;
            logic [31:0] rd;
            for (int n = 0; n < 40; n++) begin
               tick($urandom_range(0, 3));
               if_txn(32'($urandom_range(0, 63)) << 2, t0, t1, rd);
            end
         end
         begin
            int t0, t1;
            logic [31:0] rd;
            logic [3:0] we;
            for (int n = 0; n < 40; n++) begin
               tick($urandom_range(0, 3));
               we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
               ls_txn(32'($urandom_range(0, 63)) << 2, we, $urandom, t0, t1, rd);
            end
         end
      join

      // Reset during the access phase of a read drops it
      tick(2);
      if_addr = 32'h20; if_req = 1'b1; a0 = cyc;
      tick(2);
      check("rst_at_t0p2", cyc - a0, 2);
      reset = 1'b1; if_req = 1'b0;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("rst_mid");
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (if_ack || ls_ack) acks++;
      end
      check("rst_no_ack", acks, 0);
      @(posedge clk); #1;
      if_txn(32'h10, a0, a1, rda);
      check("post_rst_lat", a1 - a0, MEM_LAT + 2);
      check("post_rst_data", rda, 32'h0050_0093);

      // Both ports streaming continuously
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
`else
      exp_order = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
`endif
      base = ack_log.size();
      fork
         begin
            int t0, t1;
            logic [31:0] rd;
            repeat (3) ls_txn(32'h80, 4'h0, 32'h0, t0, t1, rd);
         end
         begin
            int t0, t1;
            logic [31:0] rd;
            repeat (3) if_txn(32'hC0, t0, t1, rd);
         end
      join
      check("stream_ack_count", ack_log.size() - base, 6);
      if (ack_log.size() >= base + 6) begin
         for (int i = 0; i < 6; i++) check($sformatf("stream_order_%0d", i), ack_log[base + i], exp_order[i]);
      end

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
